mem_stage: RTL and testbench
============================

# mem_stage

Memory pipeline stage between execute and writeback. It consumes the execute-stage register and issues exactly one data-memory request per load/store. It aligns store data and byte masks, then sign- or zero-extends load data. It drives the pipeline-wide data-memory stall and latches the memory-stage register that feeds writeback and the execute-stage forwarding unit.

## Interface
Parameters:
- none; all widths fixed at RV32 (32-bit address/data, 4-bit masks).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- mem_stall  in  1  global pipeline hold, OR of all stall sources; while high, mem_stage_reg holds.
- ex_stage_reg  in  ex_stage_t  execute-stage register: func_out (address or ALU result), rs2_rdata, rd_addr, mem_ctrl, wb_ctrl, rvfi.
- dmem_addr  out  32  word-aligned address, {func_out[31:2], 2'b00}.
- dmem_rmask  out  4  byte read mask; nonzero only in the issue cycle.
- dmem_wmask  out  4  byte write mask; nonzero only in the issue cycle.
- dmem_wdata  out  32  store data shifted into byte lanes.
- dmem_rdata  in  32  load data, valid when dmem_resp is high.
- dmem_resp  in  1  one-cycle response pulse.
- dmem_stall  out  1  memory access not yet complete.
- mem_stage_reg  out  mem_stage_t  func_out (final rd value), rd_addr, wb_ctrl, rvfi including mem fields.

## Operation
FSM states are IDLE, WAIT and DONE.
- **IDLE**
  - If mem_ctrl.mem_read or mem_ctrl.mem_write is set, issue the request this cycle: drive the mask nonzero, then go to WAIT.
  - Otherwise the stage passes through.
- **WAIT**
  - Masks are zero; dmem_addr and dmem_wdata are held.
  - On dmem_resp, capture dmem_rdata into rdata_hold.
  - On dmem_resp with mem_stall high (another stage is stalling), go to DONE.
  - On dmem_resp with mem_stall low, go to IDLE.
- **DONE**
  - No reissue; rdata_hold is held.
  - When mem_stall falls, go to IDLE.
- dmem_stall = (IDLE & mem op) | (WAIT & !dmem_resp). It falls combinationally in the dmem_resp cycle.

Store masks, with o = func_out[1:0]:
- sb → 4'b0001<<o.
- sh → 4'b0011<<o.
- sw → 4'b1111.
- wdata = rs2_rdata << 8*o.

Load masks use the same shifts. Load result by funct3:
- lb/lbu: byte (rdata >> 8*o)[7:0], sign-extended / zero-extended.
- lh/lhu: halfword (rdata >> 8*o)[15:0], sign-extended / zero-extended.
- lw: full word.

Load data source: dmem_rdata in the resp cycle, rdata_hold in DONE.

Non-memory ops: mem_stage_reg.func_out = ex_stage_reg.func_out.

Misaligned accesses are not trapped. The mask is truncated to 4 bits, so sh at o=3 → 4'b1000. Software guarantees alignment.

rvfi:
- mem_addr = dmem_addr.
- mem_rmask and mem_wmask record the issued masks.
- mem_rdata = raw word.
- mem_wdata = shifted data.

## Timing
- Reset:
  - FSM = IDLE.
  - dmem_rmask = dmem_wmask = 0.
  - dmem_stall = 0.
  - All mem_stage_reg fields = 0, so rvfi.valid = 0 and wb_ctrl.regf_we = 0.
- mem_stage_reg latches on posedge when !rst & !mem_stall.
- Minimum memory-op latency: issue in cycle N, dmem_resp in N+1, latch at end of N+1. A memory op therefore occupies the stage for at least 2 cycles; a non-memory op occupies it for 1.
- Back-to-back loads:
  - The FSM returns to IDLE in the resp cycle.
  - The next instruction arrives next cycle and issues immediately.
- If dmem_resp arrives in the issue cycle (IDLE), it is ignored. The memory must respond ≥1 cycle after the request.
- Reset mid-WAIT:
  - The FSM goes to IDLE.
  - An outstanding response arriving later is ignored.
- A request is never reissued while ex_stage_reg is held by mem_stall.

## Structure
- Add mem_fsm_t (IDLE, WAIT, DONE) and the load/store funct3 encodings (lb, lh, lw, lbu, lhu, sb, sh, sw) to rv32imc_types.
- mem_stage_t is already defined there; add rvfi mem fields if absent.
- One combinational sub-module, mem_align:
  - Inputs: funct3, offset, rs2_rdata, raw rdata.
  - Outputs: rmask, wmask, wdata, load result.
  - Keeps lane logic out of the FSM.

## Test plan
- **sw:** func_out=0x1004, rs2=0xDEADBEEF → cycle N: addr 0x1004, wmask 4'b1111, wdata 0xDEADBEEF; dmem_stall=1 until resp at N+1; one request only.
- **lb:** addr 0x2003, rdata 0x80FF_0000 → rmask 4'b1000, rd value 0xFFFFFF80; same access as lbu → 0x00000080.
- **sh:** addr 0x3002, rs2=0x1234ABCD → wmask 4'b1100, wdata 0xABCD0000.
- **Held response:** lw resp arrives while mem_stall is held high 3 cycles by another source → FSM enters DONE, no second dmem request, latched value equals the captured rdata.
- **Reset in WAIT:** rst during WAIT, then a late dmem_resp → masks 0, dmem_stall 0, mem_stage_reg all zero.
- **ALU passthrough:** add with func_out=0x55 → no request, dmem_stall 0, mem_stage_reg.func_out=0x55 next cycle.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types for the RV32 memory stage
package mem_stage_pkg;

  localparam int XLEN   = 32;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_fsm_t;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
  } mem_ctrl_t;

  typedef struct packed {
    logic regf_we;
  } wb_ctrl_t;

  typedef struct packed {
    logic              valid;
    logic [63:0]       order;
    logic [31:0]       inst;
    logic [XLEN-1:0]   pc_rdata;
    logic [XLEN-1:0]   pc_wdata;
    logic [XLEN-1:0]   mem_addr;
    logic [MASK_W-1:0] mem_rmask;
    logic [MASK_W-1:0] mem_wmask;
    logic [XLEN-1:0]   mem_rdata;
    logic [XLEN-1:0]   mem_wdata;
  } rvfi_t;

  typedef struct packed {
    logic [XLEN-1:0] func_out;
    logic [XLEN-1:0] rs2_rdata;
    logic [4:0]      rd_addr;
    mem_ctrl_t       mem_ctrl;
    wb_ctrl_t        wb_ctrl;
    rvfi_t           rvfi;
  } ex_stage_t;

  typedef struct packed {
    logic [XLEN-1:0] func_out;
    logic [4:0]      rd_addr;
    wb_ctrl_t        wb_ctrl;
    rvfi_t           rvfi;
  } mem_stage_t;

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory request/response bus
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic [XLEN-1:0]   addr;
  logic [MASK_W-1:0] rmask;
  logic [MASK_W-1:0] wmask;
  logic [XLEN-1:0]   wdata;
  logic [XLEN-1:0]   rdata;
  logic              resp;

  modport master (output addr, rmask, wmask, wdata, input rdata, resp);
  modport slave  (input addr, rmask, wmask, wdata, output rdata, resp);

endinterface

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte-lane masks, store shifting and load extension
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        offset,
  input  logic [XLEN-1:0]   rs2_rdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [MASK_W-1:0] rmask,
  output logic [MASK_W-1:0] wmask,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   load_result
);

  logic [MASK_W-1:0] lane_mask;
  logic [15:0]       lane_half;
  logic [7:0]        lane_byte;

  // Shifted masks are truncated to 4 lanes; misaligned halfwords just lose a lane.
  always_comb begin
    lane_mask = 4'b1111;
    case ({1'b0, funct3[1:0]})
      SB:      lane_mask = 4'b0001 << offset;
      SH:      lane_mask = 4'b0011 << offset;
      default: lane_mask = 4'b1111;
    endcase
  end

  assign rmask = lane_mask;
  assign wmask = lane_mask;
  assign wdata = rs2_rdata << {offset, 3'b000};

  assign lane_half = 16'(rdata >> {offset, 3'b000});
  assign lane_byte = lane_half[7:0];

  always_comb begin
    load_result = rdata;
    case (funct3)
      LB:      load_result = {{24{lane_byte[7]}}, lane_byte};
      LBU:     load_result = {24'd0, lane_byte};
      LH:      load_result = {{16{lane_half[15]}}, lane_half};
      LHU:     load_result = {16'd0, lane_half};
      default: load_result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage: one dmem request per load/store, result into mem_stage_reg
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_stall,
  input  ex_stage_t   ex_stage_reg,
  mem_stage_if.master dmem,
  output logic        dmem_stall,
  output mem_stage_t  mem_stage_reg
);

  mem_fsm_t          state, state_next;
  logic              mem_op;
  logic              issue;
  logic [XLEN-1:0]   issue_addr;
  logic [XLEN-1:0]   load_raw;
  logic [XLEN-1:0]   addr_q, wdata_q, rdata_hold;
  logic [MASK_W-1:0] rmask_q, wmask_q;
  logic [MASK_W-1:0] al_rmask, al_wmask;
  logic [XLEN-1:0]   al_wdata, al_load;
  mem_stage_t        mem_next;

  assign mem_op     = ex_stage_reg.mem_ctrl.mem_read | ex_stage_reg.mem_ctrl.mem_write;
  assign issue_addr = {ex_stage_reg.func_out[XLEN-1:2], 2'b00};

  mem_align u_align (
    .funct3      (ex_stage_reg.mem_ctrl.funct3),
    .offset      (ex_stage_reg.func_out[1:0]),
    .rs2_rdata   (ex_stage_reg.rs2_rdata),
    .rdata       (load_raw),
    .rmask       (al_rmask),
    .wmask       (al_wmask),
    .wdata       (al_wdata),
    .load_result (al_load)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    dmem_stall = 1'b0;
    dmem.addr  = addr_q;
    dmem.wdata = wdata_q;
    dmem.rmask = '0;
    dmem.wmask = '0;
    load_raw   = dmem.rdata;
    unique case (state)
      IDLE: begin
        dmem.addr  = issue_addr;
        dmem.wdata = al_wdata;
        if (mem_op) begin
          issue      = 1'b1;
          dmem_stall = 1'b1;
          dmem.rmask = ex_stage_reg.mem_ctrl.mem_read  ? al_rmask : '0;
          dmem.wmask = ex_stage_reg.mem_ctrl.mem_write ? al_wmask : '0;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (dmem.resp) state_next = mem_stall ? DONE : IDLE;
        else           dmem_stall = 1'b1;
      end
      DONE: begin
        load_raw = rdata_hold;
        if (!mem_stall) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Nothing leaves the stage while reset is asserted, even with a load/store sitting in ex.
    if (rst) begin
      issue      = 1'b0;
      dmem_stall = 1'b0;
      dmem.rmask = '0;
      dmem.wmask = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      rmask_q    <= '0;
      wmask_q    <= '0;
      rdata_hold <= '0;
    end else begin
      if (issue) begin
        addr_q  <= issue_addr;
        wdata_q <= al_wdata;
        rmask_q <= dmem.rmask;
        wmask_q <= dmem.wmask;
      end
      if (state == WAIT && dmem.resp) rdata_hold <= dmem.rdata;
    end
  end

  // Only sampled in WAIT-with-resp, DONE, or IDLE without a memory op; the issue cycle always stalls.
  always_comb begin
    mem_next          = '0;
    mem_next.func_out = ex_stage_reg.mem_ctrl.mem_read ? al_load : ex_stage_reg.func_out;
    mem_next.rd_addr  = ex_stage_reg.rd_addr;
    mem_next.wb_ctrl  = ex_stage_reg.wb_ctrl;
    mem_next.rvfi     = ex_stage_reg.rvfi;
    mem_next.rvfi.mem_addr  = '0;
    mem_next.rvfi.mem_rmask = '0;
    mem_next.rvfi.mem_wmask = '0;
    mem_next.rvfi.mem_rdata = '0;
    mem_next.rvfi.mem_wdata = '0;
    if (mem_op) begin
      mem_next.rvfi.mem_addr  = addr_q;
      mem_next.rvfi.mem_rmask = rmask_q;
      mem_next.rvfi.mem_wmask = wmask_q;
      mem_next.rvfi.mem_rdata = ex_stage_reg.mem_ctrl.mem_read  ? load_raw : '0;
      mem_next.rvfi.mem_wdata = ex_stage_reg.mem_ctrl.mem_write ? wdata_q  : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)             mem_stage_reg <= '0;
    else if (!mem_stall) mem_stage_reg <= mem_next;
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized and directed bench for mem_stage against a byte-lane model
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic       clk;
  logic       rst;
  logic       other_stall;
  logic       mem_stall;
  logic       dmem_stall;
  ex_stage_t  ex;
  mem_stage_t mem_stage_reg;
  int         checks;
  int         failures;
  logic [63:0] order_cnt;

  mem_stage_if dif ();

  assign mem_stall = dmem_stall | other_stall;

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .mem_stall     (mem_stall),
    .ex_stage_reg  (ex),
    .dmem          (dif),
    .dmem_stall    (dmem_stall),
    .mem_stage_reg (mem_stage_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: byte count from funct3, lanes counted from the low address offset.
  function automatic void model(input logic [2:0] f3, input logic [1:0] o,
                                input logic [31:0] rs2, input logic [31:0] word,
                                output logic [3:0] mask, output logic [31:0] wdata,
                                output logic [31:0] res);
    int nbytes;
    longint unsigned v, lim;
    nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    wdata  = 32'(64'(rs2) << (8 * o));
    if (nbytes == 4) begin
      mask = 4'hF;
      res  = word;
    end else begin
      mask = 4'(((1 << nbytes) - 1) << o);
      lim  = 64'd1 << (8 * nbytes);
      v    = (64'(word) >> (8 * o)) % lim;
      if (!f3[2] && v >= lim / 2) v = v + 64'hFFFF_FFFF_0000_0000 - lim + 64'h1_0000_0000;
      res  = 32'(v);
    end
  endfunction

  task automatic alu_op(input string tag, input logic [31:0] val);
    ex                  = '0;
    ex.func_out         = val;
    ex.rd_addr          = 5'($urandom);
    ex.wb_ctrl.regf_we  = 1'b1;
    ex.rvfi.valid       = 1'b1;
    ex.rvfi.order       = order_cnt;
    order_cnt++;
    other_stall = 1'b0;
    dif.resp    = 1'b0;
    #1;
    chk({tag, "_stall"}, dmem_stall, 0);
    chk({tag, "_masks"}, {dif.rmask, dif.wmask}, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk({tag, "_func_out"}, mem_stage_reg.func_out, val);
    chk({tag, "_rd"}, mem_stage_reg.rd_addr, ex.rd_addr);
    chk({tag, "_rvfi_masks"}, {mem_stage_reg.rvfi.mem_rmask, mem_stage_reg.rvfi.mem_wmask}, 0);
  endtask

  task automatic mem_op(input string tag, input logic is_load, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [31:0] word, input int delay, input int hold);
    logic [3:0]  m_mask;
    logic [31:0] m_wdata, m_res;
    mem_stage_t  prev;
    int          reqs;
    model(f3, addr[1:0], rs2, word, m_mask, m_wdata, m_res);
    ex                    = '0;
    ex.func_out           = addr;
    ex.rs2_rdata          = rs2;
    ex.rd_addr            = 5'($urandom);
    ex.mem_ctrl.mem_read  = is_load;
    ex.mem_ctrl.mem_write = !is_load;
    ex.mem_ctrl.funct3    = f3;
    ex.wb_ctrl.regf_we    = is_load;
    ex.rvfi.valid         = 1'b1;
    ex.rvfi.order         = order_cnt;
    order_cnt++;
    other_stall = 1'b0;
    dif.resp    = 1'b0;
    dif.rdata   = $urandom;
    prev        = mem_stage_reg;
    #1;
    reqs = ((dif.rmask | dif.wmask) != 0) ? 1 : 0;
    chk({tag, "_issue_stall"}, dmem_stall, 1);
    chk({tag, "_addr"}, dif.addr, {addr[31:2], 2'b00});
    chk({tag, "_rmask"}, dif.rmask, is_load ? m_mask : 4'h0);
    chk({tag, "_wmask"}, dif.wmask, is_load ? 4'h0 : m_mask);
    if (!is_load) chk({tag, "_wdata"}, dif.wdata, m_wdata);
    @(posedge clk);
    for (int i = 1; i < delay; i++) begin
      @(negedge clk);
      dif.rdata = $urandom;
      #1;
      if ((dif.rmask | dif.wmask) != 0) reqs++;
      chk({tag, "_wait_stall"}, dmem_stall, 1);
      chk({tag, "_wait_addr"}, dif.addr, {addr[31:2], 2'b00});
      @(posedge clk);
    end
    @(negedge clk);
    dif.resp    = 1'b1;
    dif.rdata   = word;
    other_stall = (hold > 0);
    #1;
    if ((dif.rmask | dif.wmask) != 0) reqs++;
    chk({tag, "_resp_stall"}, dmem_stall, 0);
    @(posedge clk);
    for (int h = 1; h <= hold; h++) begin
      @(negedge clk);
      dif.resp    = 1'b0;
      dif.rdata   = $urandom;
      other_stall = (h < hold);
      #1;
      if ((dif.rmask | dif.wmask) != 0) reqs++;
      chk({tag, "_done_stall"}, dmem_stall, 0);
      chk({tag, "_held_reg"}, mem_stage_reg === prev, 1);
      @(posedge clk);
    end
    @(negedge clk);
    dif.resp    = 1'b0;
    other_stall = 1'b0;
    #1;
    chk({tag, "_requests"}, reqs, 1);
    chk({tag, "_func_out"}, mem_stage_reg.func_out, is_load ? m_res : addr);
    chk({tag, "_regf_we"}, mem_stage_reg.wb_ctrl.regf_we, is_load);
    chk({tag, "_rvfi_order"}, mem_stage_reg.rvfi.order, ex.rvfi.order);
    chk({tag, "_rvfi_addr"}, mem_stage_reg.rvfi.mem_addr, {addr[31:2], 2'b00});
    chk({tag, "_rvfi_masks"}, {mem_stage_reg.rvfi.mem_rmask, mem_stage_reg.rvfi.mem_wmask},
        is_load ? {m_mask, 4'h0} : {4'h0, m_mask});
    chk({tag, "_rvfi_rdata"}, mem_stage_reg.rvfi.mem_rdata, is_load ? word : 32'h0);
    chk({tag, "_rvfi_wdata"}, mem_stage_reg.rvfi.mem_wdata, is_load ? 32'h0 : m_wdata);
  endtask

  initial begin
    int          kind;
    logic [2:0]  f3;
    logic [31:0] addr;
    checks      = 0;
    failures    = 0;
    order_cnt   = 64'd1;
    rst         = 1'b1;
    other_stall = 1'b0;
    dif.resp    = 1'b0;
    dif.rdata   = '0;
    ex                    = '0;
    ex.func_out           = 32'h0000_1000;
    ex.mem_ctrl.mem_write = 1'b1;
    ex.mem_ctrl.funct3    = SW;

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_stall", dmem_stall, 0);
    chk("reset_masks", {dif.rmask, dif.wmask}, 0);
    chk("reset_reg_zero", mem_stage_reg === '0, 1);
    @(negedge clk);
    rst = 1'b0;
    ex  = '0;

    alu_op("alu_55", 32'h55);
    mem_op("sw", 1'b0, SW, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 1, 0);
    mem_op("lb", 1'b1, LB, 32'h0000_2003, 32'h0, 32'h80FF_0000, 1, 0);
    mem_op("lbu", 1'b1, LBU, 32'h0000_2003, 32'h0, 32'h80FF_0000, 1, 0);
    mem_op("sh", 1'b0, SH, 32'h0000_3002, 32'h1234_ABCD, 32'h0, 1, 0);
    mem_op("sh_o3", 1'b0, SH, 32'h0000_3003, 32'h1234_ABCD, 32'h0, 1, 0);
    mem_op("lw_held", 1'b1, LW, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 1, 3);
    mem_op("lh_b2b", 1'b1, LH, 32'h0000_4002, 32'h0, 32'h8001_7FFF, 1, 0);
    mem_op("lhu_b2b", 1'b1, LHU, 32'h0000_4002, 32'h0, 32'h8001_7FFF, 2, 0);

    ex                   = '0;
    ex.func_out          = 32'h0000_5000;
    ex.mem_ctrl.mem_read = 1'b1;
    ex.mem_ctrl.funct3   = LW;
    #1;
    chk("rstwait_issue", dif.rmask, 4'hF);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstwait_stall_in_rst", dmem_stall, 0);
    chk("rstwait_masks_in_rst", {dif.rmask, dif.wmask}, 0);
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    ex        = '0;
    dif.resp  = 1'b1;
    dif.rdata = 32'h1357_9BDF;
    #1;
    chk("rstwait_late_stall", dmem_stall, 0);
    chk("rstwait_late_masks", {dif.rmask, dif.wmask}, 0);
    chk("rstwait_reg_zero", mem_stage_reg === '0, 1);
    @(posedge clk);
    @(negedge clk);
    dif.resp = 1'b0;
    #1;
    chk("rstwait_reg_after", mem_stage_reg === '0, 1);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 8);
      addr = $urandom;
      case (kind)
        1: f3 = LB;
        2: f3 = LH;
        3: f3 = LW;
        4: f3 = LBU;
        5: f3 = LHU;
        6: f3 = SB;
        7: f3 = SH;
        default: f3 = SW;
      endcase
      if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
      if (kind == 0)      alu_op("rnd_alu", addr);
      else if (kind <= 5) mem_op("rnd_load", 1'b1, f3, addr, $urandom, $urandom,
                                 $urandom_range(1, 3), $urandom_range(0, 2));
      else                mem_op("rnd_store", 1'b0, f3, addr, $urandom, $urandom,
                                 $urandom_range(1, 3), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
